l3_result_serializer: RTL and testbench
=======================================

// Module: l3_result_serializer
// PURPOSE
//  Read side of the L3 adder-array output bus. Accepts a packed word of array_size
//  (data_width+1)-bit sums, buffers up to two words, and streams them out one lane
//  per transfer over valid/ready. Sits between the convolution L3 adder stage and
//  downstream accumulation/writeback, decoupling the adder from back-pressure.
// PARAMETERS
//  data_width  18  operand width of the adder stage; each lane is data_width+1 bits
//  array_size  2   lanes per packed word; lane i = in_data[(i+1)*LW-1 : i*LW], LW=data_width+1
// PORTS
//  clk        in   1                       system clock, rising edge
//  reset      in   1                       asynchronous, active-low reset
//  in_valid   in   1                       packed word present on in_data
//  in_data    in   array_size*(data_width+1)  packed lane sums, lane 0 in LSBs
//  in_ready   out  1                       buffer can accept a word this cycle
//  out_valid  out  1                       out_data holds a valid lane
//  out_ready  in   1                       downstream accepts lane this cycle
//  out_data   out  data_width+1            current lane value, passed unmodified
//  out_lane   out  clog2(array_size) (min 1)  index of lane on out_data
//  out_last   out  1                       out_data is lane array_size-1 of its word
//  drop_err   out  1                       sticky: word offered while in_ready low
// BEHAVIOUR
//  - Reset (async, reset==0): buffer count 0, lane_cnt 0, out_valid 0, out_data 0,
//    out_lane 0, out_last 0, in_ready 1, drop_err 0. In-flight words are discarded.
//  - Occupancy FSM: EMPTY(0) -> ONE(1) -> FULL(2). push = in_valid & in_ready;
//    pop = out_valid & out_ready & out_last.
//    EMPTY: push->ONE. ONE: push&!pop->FULL, !push&pop->EMPTY, both->ONE.
//    FULL: pop->ONE (push impossible). No other transitions.
//  - in_ready = (state != FULL) and depends on registered state only; no
//    combinational path from out_ready to in_ready. A pop in FULL frees a slot
//    only from the next cycle.
//  - in_valid & !in_ready: word dropped, buffer unchanged, drop_err set to 1 and
//    held until reset.
//  - out_valid = (state != EMPTY). out_data = lane[lane_cnt] of head word;
//    out_lane = lane_cnt; out_last = (lane_cnt == array_size-1). All outputs come
//    from registers and a mux only.
//  - Latency: word pushed in cycle N into EMPTY -> lane 0 visible with out_valid
//    in cycle N+1. Full word drains in array_size cycles with out_ready held high.
//  - Transfer (out_valid & out_ready): lane_cnt+1; on out_last, lane_cnt->0 and
//    head advances to second entry. Back-to-back words drain with no bubble.
//  - out_ready low: out_data, out_lane and out_last hold stable while out_valid is high.
//  - array_size==1: out_last is high whenever out_valid is high; lane_cnt stays 0.
//  - Data is never modified. No sign extension or truncation; width is exactly LW.
// STRUCTURE
//  - Shared header conv_defs.vh holds the lane width macro (data_width+1), the
//    clog2 lane-index width function, and the high/low value macros already used
//    in the convolution blocks.
//  - One sub-module: fifo2_buffer, a 2-entry ping-pong storage with wr/rd pointers
//    and count. This block holds the lane counter, the output mux and drop_err.
// TESTING (data_width=18, array_size=2, LW=19)
//  1 reset mid-drain: push word, release reset low after lane 0 -> all outputs at
//    reset values, next push restarts at lane 0.
//  2 single word {19'h7FFFF,19'h00005}, out_ready=1 -> N+1: data 0x00005 lane0
//    last0; N+2: 0x7FFFF lane1 last1; N+3: out_valid 0.
//  3 three words pushed back-to-back, out_ready=0 -> in_ready 0 after two pushes,
//    third word dropped, drop_err=1 and stays 1; outputs hold lane 0 of word 1.
//  4 FULL, then out_ready=1 -> six... only four lanes out (words 1,2), in order,
//    no bubble; in_ready rises the cycle after word 1's last lane.
//  5 ONE state, push coincident with pop of last lane -> state stays ONE, next
//    cycle shows lane 0 of new word, no lost or duplicated lane.
//  6 random out_ready toggling over 1000 words, scoreboard -> lane order exact,
//    out_data stable while stalled, drop_err 0 when in_valid honours in_ready.

Source files
------------

// File: rtl/l3_result_serializer_pkg.sv
// Shared definitions for the L3 result serializer: occupancy states, lane
// width / lane index width helpers and the common high/low signal values.
package l3_result_serializer_pkg;

    localparam logic SIG_HIGH = 1'b1;
    localparam logic SIG_LOW  = 1'b0;

    // Word buffer occupancy; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // Each adder lane carries one extra bit for the carry out of the sum.
    function automatic int lane_width(input int dw);
        return dw + 1;
    endfunction

    // Lane index width, never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l3_result_serializer_fifo2_buffer.sv
// Two-entry ping-pong word store. The occupancy FSM state is the entry count;
// push is never presented while full and pop never while empty.
module l3_result_serializer_fifo2_buffer
    import l3_result_serializer_pkg::*;
#(
    parameter int WORD_W = 38
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [WORD_W-1:0] rd_data_o,
    output occ_state_e        state_o
);

    occ_state_e        state_q, state_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [WORD_W-1:0] mem_q [2];

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: a simultaneous push and pop keeps ONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push_i) state_d = ST_ONE;
            ST_ONE: begin
                if (push_i && !pop_i)      state_d = ST_FULL;
                else if (!push_i && pop_i) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop_i) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Storage and ping-pong pointers; cleared on reset so the output mux reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Head word and state outputs come straight from registers.
    always_comb begin
        rd_data_o = mem_q[rd_ptr_q];
        state_o   = state_q;
    end

endmodule

// File: rtl/l3_result_serializer.sv
// Buffers packed adder-array words (up to two) and streams them out one lane
// per transfer. Holds the lane counter, output lane mux and sticky drop flag.
//
// Handshake: a word moves in when in_valid && in_ready at a rising edge; a lane
// moves out when out_valid && out_ready at a rising edge. in_ready depends only
// on registered occupancy, so out_ready never reaches in_ready combinationally,
// and outputs stay stable while out_valid is high and out_ready is low.
module l3_result_serializer
    import l3_result_serializer_pkg::*;
#(
    parameter int data_width = 18,
    parameter int array_size = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           in_valid,
    input  logic [array_size*lane_width(data_width)-1:0]   in_data,
    output logic                                           in_ready,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [lane_width(data_width)-1:0]              out_data,
    output logic [lane_idx_w(array_size)-1:0]              out_lane,
    output logic                                           out_last,
    output logic                                           drop_err,
    output logic [1:0]                                     dbg_state
);

    localparam int LW     = lane_width(data_width);
    localparam int WORD_W = array_size * LW;
    localparam int LANE_W = lane_idx_w(array_size);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(array_size - 1);

    occ_state_e        state;
    logic [WORD_W-1:0] head_word;
    logic              push, pop, xfer;
    logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
    logic              drop_err_q, drop_err_d;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_last  = (lane_cnt_q == LAST_LANE);
    assign xfer      = out_valid & out_ready;
    assign pop       = xfer & out_last;
    assign push      = in_valid & in_ready;
    assign out_lane  = lane_cnt_q;
    assign drop_err  = drop_err_q;
    assign dbg_state = state;

    l3_result_serializer_fifo2_buffer #(
        .WORD_W (WORD_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (head_word),
        .state_o   (state)
    );

    // Lane counter advances per transfer and wraps after the last lane.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        if (xfer) begin
            lane_cnt_d = out_last ? '0 : lane_cnt_q + LANE_W'(1);
        end
    end

    // A word offered while the buffer is full is lost; remember it until reset.
    always_comb begin
        drop_err_d = drop_err_q;
        if (in_valid && !in_ready) begin
            drop_err_d = SIG_HIGH;
        end
    end

    // Lane counter and drop flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt_q <= '0;
            drop_err_q <= SIG_LOW;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Output lane mux over the head word; lane 0 sits in the LSBs.
    always_comb begin
        out_data = head_word[LW*int'(lane_cnt_q) +: LW];
    end

endmodule

// File: tb/tb_l3_result_serializer.sv
// Directed bench for the L3 result serializer (data_width=18, array_size=2).
module tb_l3_result_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [37:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [18:0] out_data;
    logic [0:0]  out_lane;
    logic        out_last;
    logic        drop_err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // expected lane entries: {last, lane, data}
    logic [20:0] exp_q[$];

    l3_result_serializer #(
        .data_width (18),
        .array_size (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .drop_err  (drop_err),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [18:0] d,
                             input logic l, input logic last);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".lane"},  64'(out_lane),  64'(l));
        check({tag, ".last"},  64'(out_last),  64'(last));
    endtask

    task automatic check_reset_vals(input string tag);
        check_out(tag, 1'b0, 19'h0, 1'b0, 1'b0);
        check({tag, ".in_ready"}, 64'(in_ready),  64'd1);
        check({tag, ".drop_err"}, 64'(drop_err),  64'd0);
        check({tag, ".state"},    64'(dbg_state), 64'd0);
    endtask

    initial begin
        logic [20:0] cur, prev_val, e;
        logic        prev_stall;
        int          words_sent, cycles;
        logic [18:0] l0, l1;

        // reset
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        step();

        // single word, out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {19'h7FFFF, 19'h00005};
        step();
        in_valid = 1'b0;
        check_out("single.n1", 1'b1, 19'h00005, 1'b0, 1'b0);
        step();
        check_out("single.n2", 1'b1, 19'h7FFFF, 1'b1, 1'b1);
        step();
        check("single.n3.valid", 64'(out_valid), 64'd0);
        check("single.n3.state", 64'(dbg_state), 64'd0);

        // three words back-to-back with out_ready low: third is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {19'h00A11, 19'h00A01};
        step();
        check("fill.w1.state", 64'(dbg_state), 64'd1);
        check("fill.w1.in_ready", 64'(in_ready), 64'd1);
        in_data = {19'h00B12, 19'h00B02};
        step();
        check("fill.w2.state", 64'(dbg_state), 64'd2);
        check("fill.w2.in_ready", 64'(in_ready), 64'd0);
        check("fill.w2.drop_err", 64'(drop_err), 64'd0);
        in_data = {19'h4C013, 19'h4C003};
        step();
        in_valid = 1'b0;
        check("fill.w3.drop_err", 64'(drop_err), 64'd1);
        check("fill.w3.state", 64'(dbg_state), 64'd2);
        check_out("fill.w3.hold", 1'b1, 19'h00A01, 1'b0, 1'b0);
        step();
        check("fill.sticky", 64'(drop_err), 64'd1);
        check_out("fill.hold2", 1'b1, 19'h00A01, 1'b0, 1'b0);

        // drain from FULL: four lanes, no bubble, in_ready returns after word 1
        out_ready = 1'b1;
        step();
        check_out("drain.l1", 1'b1, 19'h00A11, 1'b1, 1'b1);
        check("drain.l1.in_ready", 64'(in_ready), 64'd0);
        step();
        check_out("drain.l2", 1'b1, 19'h00B02, 1'b0, 1'b0);
        check("drain.l2.in_ready", 64'(in_ready), 64'd1);
        step();
        check_out("drain.l3", 1'b1, 19'h00B12, 1'b1, 1'b1);
        step();
        check("drain.end.valid", 64'(out_valid), 64'd0);
        check("drain.end.drop_err", 64'(drop_err), 64'd1);

        // reset asserted mid-drain
        in_valid = 1'b1;
        in_data  = {19'h12345, 19'h54321};
        step();
        in_valid = 1'b0;
        check_out("mid.l0", 1'b1, 19'h54321, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_vals("mid.rst");
        #1;
        reset = 1'b1;
        step();
        check_reset_vals("mid.after");
        in_valid = 1'b1;
        in_data  = {19'h0AAAA, 19'h15555};
        step();
        in_valid = 1'b0;
        check_out("restart.l0", 1'b1, 19'h15555, 1'b0, 1'b0);
        step();
        check_out("restart.l1", 1'b1, 19'h0AAAA, 1'b1, 1'b1);
        step();
        check("restart.end", 64'(out_valid), 64'd0);

        // push coincident with pop of last lane in ONE
        in_valid = 1'b1;
        in_data  = {19'h00002, 19'h00001};
        step();
        in_valid = 1'b0;
        check_out("coin.a0", 1'b1, 19'h00001, 1'b0, 1'b0);
        step();
        check_out("coin.a1", 1'b1, 19'h00002, 1'b1, 1'b1);
        check("coin.a1.state", 64'(dbg_state), 64'd1);
        in_valid = 1'b1;
        in_data  = {19'h00004, 19'h00003};
        step();
        in_valid = 1'b0;
        check("coin.state", 64'(dbg_state), 64'd1);
        check_out("coin.b0", 1'b1, 19'h00003, 1'b0, 1'b0);
        step();
        check_out("coin.b1", 1'b1, 19'h00004, 1'b1, 1'b1);
        step();
        check("coin.end", 64'(out_valid), 64'd0);

        // random traffic with scoreboard
        words_sent = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_val   = '0;
        while ((words_sent < 1000 || exp_q.size() != 0 || out_valid) && cycles < 40000) begin
            cur = {out_last, out_lane, out_data};
            if (prev_stall && out_valid) begin
                check("rand.stable", 64'(cur), 64'(prev_val));
            end
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (words_sent < 1000) && in_ready && ($urandom_range(0, 3) != 0);
            l0 = 19'($urandom);
            l1 = 19'($urandom);
            in_data = {l1, l0};
            if (in_valid) begin
                exp_q.push_back({1'b0, 1'b0, l0});
                exp_q.push_back({1'b1, 1'b1, l1});
                words_sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand.unexpected_lane", 64'(cur), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand.lane", 64'(cur), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_val   = cur;
            step();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand.timeout", 64'(cycles < 40000), 64'd1);
        check("rand.words", 64'(words_sent), 64'd1000);
        check("rand.queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand.drop_err", 64'(drop_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
